imm_extend_stage: RTL and testbench

//  Pipelined LEGv8 immediate generator with valid/ready handshake. It takes a 32-bit instruction

---
 rtl/legv8_pkg.sv | 26 ++
 rtl/pipe_skid_buf.sv | 53 +++++
 rtl/imm_extend_stage.sv | 77 +++++++
 tb/tb_imm_extend_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: immediate format tags and the opcode patterns
// the immediate generator recognises.
package legv8_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    B    = 3'd1,
    CB   = 3'd2,
    D    = 3'd3,
    I    = 3'd4
  } imm_type_t;

  localparam int TYPE_W = 3;

  // Opcode fields, left-aligned at ins[31]; widths differ by format.
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready pipeline buffer (output register plus skid register)
// that keeps full throughput under backpressure while preserving FIFO order.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_xfer;
  logic         out_free;

  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && in_ready;
  // The output register may load whenever it is empty or being drained.
  assign out_free = !out_valid || out_ready;

  // NOTE: the data registers are reset as well, because the stage must present
  // an all-zero payload while in reset, not whatever was last held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      // The skid entry is older than anything arriving now, so it goes first.
      // While the skid is full in_ready is low, so no input can collide here.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        out_data   <= in_data;
        out_valid  <= 1'b1;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Pipelined LEGv8 immediate generator: decodes B/CB/D/I formats from the
// opcode, extends/scales the immediate and buffers it behind valid/ready.
module imm_extend_stage
  import legv8_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter bit SHIFT_BRANCH = 1'b1,
  parameter bit ILLEGAL_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [31:0]       ins,
  output logic              imm_valid,
  input  logic              imm_ready,
  output logic [DATA_W-1:0] imm,
  output imm_type_t         imm_type,
  output logic              illegal
);

  localparam int PAY_W = DATA_W + TYPE_W + 1;

  // Payload layout: {illegal, imm_type, imm}.
  function automatic logic [PAY_W-1:0] decode(input logic [31:0] w);
    logic [DATA_W-1:0] val;
    imm_type_t         typ;
    logic              bad;
    val = '0;
    typ = NONE;
    bad = 1'b0;
    if (w[31:26] == OP_B || w[31:26] == OP_BL) begin
      typ = B;
      val = {{(DATA_W-26){w[25]}}, w[25:0]};
      if (SHIFT_BRANCH) val = val << 2;
    end else if (w[31:24] == OP_CBZ || w[31:24] == OP_CBNZ ||
                 w[31:24] == OP_BCOND) begin
      typ = CB;
      val = {{(DATA_W-19){w[23]}}, w[23:5]};
      if (SHIFT_BRANCH) val = val << 2;
    end else if (w[31:21] == OP_LDUR || w[31:21] == OP_STUR) begin
      typ = D;
      val = {{(DATA_W-9){w[20]}}, w[20:12]};
    end else if (w[31:22] == OP_ADDI || w[31:22] == OP_SUBI) begin
      typ = I;
      val = {{(DATA_W-12){1'b0}}, w[21:10]};
    end else begin
      bad = 1'b1;
      val = ILLEGAL_ZERO ? '0 : {{(DATA_W-26){w[25]}}, w[25:0]};
    end
    return {bad, typ, val};
  endfunction

  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;
  logic             buf_ready;

  assign pay_in    = decode(ins);
  // Hold off upstream for the whole time reset is asserted.
  assign ins_ready = buf_ready && !rst;

  pipe_skid_buf #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ins_valid),
    .in_ready  (buf_ready),
    .in_data   (pay_in),
    .out_valid (imm_valid),
    .out_ready (imm_ready),
    .out_data  (pay_out)
  );

  assign imm      = pay_out[DATA_W-1:0];
  assign imm_type = imm_type_t'(pay_out[DATA_W +: TYPE_W]);
  assign illegal  = pay_out[PAY_W-1];

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: decode vectors on two parameterisations,
// backpressure ordering through the skid buffer, and reset with entries held.
module tb_imm_extend_stage;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid, ins_valid2;
  logic        ins_ready, ins_ready2;
  logic [31:0] ins;
  logic        imm_valid, imm_valid2;
  logic        imm_ready, imm_ready2;
  logic [63:0] imm, imm2;
  imm_type_t   imm_type, imm_type2;
  logic        illegal, illegal2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_extend_stage dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .imm_valid(imm_valid), .imm_ready(imm_ready),
    .imm(imm), .imm_type(imm_type), .illegal(illegal)
  );

  // Unscaled branches and raw illegal immediates.
  imm_extend_stage #(.DATA_W(64), .SHIFT_BRANCH(1'b0), .ILLEGAL_ZERO(1'b0)) dut2 (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid2), .ins_ready(ins_ready2), .ins(ins),
    .imm_valid(imm_valid2), .imm_ready(imm_ready2),
    .imm(imm2), .imm_type(imm_type2), .illegal(illegal2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] w;
    logic [63:0] imm1;
    logic [63:0] imm2;
    imm_type_t   t;
    logic        ill;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, B,    1'b0};
    vecs[1]  = '{32'h9400_0001, 64'h4,                   64'h1,                   B,    1'b0};
    vecs[2]  = '{32'hB400_0040, 64'h8,                   64'h2,                   CB,   1'b0};
    vecs[3]  = '{32'hB580_0000, 64'hFFFF_FFFF_FFF0_0000, 64'hFFFF_FFFF_FFFC_0000, CB,   1'b0};
    vecs[4]  = '{32'h54FF_FFE0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, CB,   1'b0};
    vecs[5]  = '{32'hF85F_8000, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, D,    1'b0};
    vecs[6]  = '{32'hF801_0000, 64'h10,                  64'h10,                  D,    1'b0};
    vecs[7]  = '{32'h9100_0400, 64'h1,                   64'h1,                   I,    1'b0};
    vecs[8]  = '{32'hD13F_FC00, 64'hFFF,                 64'hFFF,                 I,    1'b0};
    vecs[9]  = '{32'h0000_0000, 64'h0,                   64'h0,                   NONE, 1'b1};
    vecs[10] = '{32'hF860_0000, 64'h0,                   64'h60_0000,             NONE, 1'b1};
    vecs[11] = '{32'h03FF_FFFF, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, NONE, 1'b1};

    rst = 1'b1; ins = '0; ins_valid = 1'b0; ins_valid2 = 1'b0;
    imm_ready = 1'b1; imm_ready2 = 1'b1;

    // Reset state.
    #2;
    check("rst_valid", 64'(imm_valid), 64'd0);
    check("rst_imm",   imm,            64'd0);
    check("rst_type",  64'(imm_type),  64'(NONE));
    check("rst_ill",   64'(illegal),   64'd0);
    check("rst_ready", 64'(ins_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Decode vectors, one at a time with downstream always ready.
    for (int i = 0; i < 12; i++) begin
      ins = vecs[i].w; ins_valid = 1'b1; ins_valid2 = 1'b1;
      check($sformatf("v%0d_rdy", i), 64'(ins_ready), 64'd1);
      @(posedge clk); #1;
      ins_valid = 1'b0; ins_valid2 = 1'b0;
      check($sformatf("v%0d_valid", i), 64'(imm_valid), 64'd1);
      check($sformatf("v%0d_imm", i),   imm,            vecs[i].imm1);
      check($sformatf("v%0d_type", i),  64'(imm_type),  64'(vecs[i].t));
      check($sformatf("v%0d_ill", i),   64'(illegal),   64'(vecs[i].ill));
      check($sformatf("v%0d_imm2", i),  imm2,           vecs[i].imm2);
      check($sformatf("v%0d_type2", i), 64'(imm_type2), 64'(vecs[i].t));
      @(posedge clk); #1;
      check($sformatf("v%0d_drain", i), 64'(imm_valid), 64'd0);
    end

    // Backpressure: A, B, C back-to-back with downstream stalled.
    imm_ready = 1'b0;
    ins = 32'h17FF_FFFF; ins_valid = 1'b1;                // A
    @(posedge clk); #1;
    check("bp_a_out",   imm,            64'hFFFF_FFFF_FFFF_FFFC);
    check("bp_rdy_a",   64'(ins_ready), 64'd1);
    ins = 32'hB400_0040;                                  // B
    @(posedge clk); #1;
    check("bp_rdy_b",   64'(ins_ready), 64'd0);
    check("bp_hold1",   imm,            64'hFFFF_FFFF_FFFF_FFFC);
    ins = 32'hF85F_8000;                                  // C
    @(posedge clk); #1;
    check("bp_hold2",   imm,            64'hFFFF_FFFF_FFFF_FFFC);
    check("bp_hold2_t", 64'(imm_type),  64'(B));
    check("bp_valid",   64'(imm_valid), 64'd1);
    check("bp_rdy_c",   64'(ins_ready), 64'd0);
    imm_ready = 1'b1;
    @(posedge clk); #1;                                   // A out, B from skid
    check("bp_b_out",   imm,            64'h8);
    check("bp_b_type",  64'(imm_type),  64'(CB));
    check("bp_rdy_2",   64'(ins_ready), 64'd1);
    @(posedge clk); #1;                                   // B out, C accepted
    ins_valid = 1'b0;
    check("bp_c_out",   imm,            64'hFFFF_FFFF_FFFF_FFF8);
    check("bp_c_type",  64'(imm_type),  64'(D));
    @(posedge clk); #1;
    check("bp_empty",   64'(imm_valid), 64'd0);

    // Reset with both entries occupied.
    imm_ready = 1'b0;
    ins = 32'h9400_0001; ins_valid = 1'b1;
    @(posedge clk); #1;
    ins = 32'hD13F_FC00;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    check("rs_full",    64'(ins_ready), 64'd0);
    check("rs_pre_v",   64'(imm_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rs_valid",   64'(imm_valid), 64'd0);
    check("rs_imm",     imm,            64'd0);
    check("rs_ready",   64'(ins_ready), 64'd0);
    @(negedge clk) rst = 1'b0;
    imm_ready = 1'b1;
    @(posedge clk); #1;
    check("rs_gone",    64'(imm_valid), 64'd0);
    check("rs_rdy",     64'(ins_ready), 64'd1);
    ins = 32'h9100_0400; ins_valid = 1'b1;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    check("rs_new_v",   64'(imm_valid), 64'd1);
    check("rs_new_imm", imm,            64'h1);
    check("rs_new_t",   64'(imm_type),  64'(I));
    @(posedge clk); #1;
    check("rs_drain",   64'(imm_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
